// File: rtl/aqp_ovl_text_render.sv
// Overlay text renderer: fetches one line of character cells into a
// double-buffered line store, then streams fg/bg colour indices per pixel.
module aqp_ovl_text_render #(
  parameter int COLS   = 40,
  parameter int ROWS   = 25,
  parameter int PIXELS = 320
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  line_idx,
  output logic [9:0]  text_addr,
  input  logic [15:0] text_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        pix_start,
  input  logic        pix_en,
  output logic [3:0]  pix_color,
  output logic        pix_valid,
  output logic        busy
);

  localparam int CW     = $clog2(COLS);
  localparam int BW     = $clog2(2 * COLS);
  localparam int XW     = $clog2(PIXELS + 1);
  localparam int STAGES = 2;
  localparam logic [8:0] LINES = 9'(ROWS * 8);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t            state, state_nx;
  logic [STAGES:0]   vld_pipe;   // [0] addr on bus, [1] text_data valid, [2] font_data valid
  logic [CW-1:0]     idx0, idx1, idx2;
  logic [2:0]        lsub;
  logic [7:0]        attr;
  logic [10:0]       font_addr_q;
  logic              ready, rd_sel;
  logic [1:0]        bank_vld;
  logic [XW-1:0]     x;
  logic [15:0]       lbuf [2*COLS];

  logic              line_ok, last_wr, issue;
  logic [BW-1:0]     wr_ptr;

  assign line_ok = line_start && ({1'b0, line_idx} < LINES);
  assign last_wr = vld_pipe[2] && (idx2 == CW'(COLS - 1));
  assign issue   = vld_pipe[0] && (idx0 != CW'(COLS - 1));
  assign busy    = (state == FETCH);

  // font address follows text_data combinationally, then holds once the pipe drains
  assign font_addr = vld_pipe[1] ? {text_data[7:0], lsub} : font_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (line_ok) state_nx = FETCH;
      FETCH:   if (!line_ok && last_wr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe    <= '0;
      idx0        <= '0;
      idx1        <= '0;
      idx2        <= '0;
      lsub        <= '0;
      attr        <= '0;
      text_addr   <= '0;
      font_addr_q <= '0;
    end else begin
      idx1        <= idx0;
      idx2        <= idx1;
      font_addr_q <= font_addr;
      if (vld_pipe[1]) attr <= text_data[15:8];
      if (line_ok) begin
        // restart also flushes any in-flight columns of an aborted fetch
        lsub      <= line_idx[2:0];
        text_addr <= 10'(line_idx[7:3] * COLS);
        idx0      <= '0;
        vld_pipe  <= 3'b001;
      end else if (state == FETCH) begin
        vld_pipe <= {vld_pipe[1], vld_pipe[0], issue};
        if (issue) begin
          text_addr <= text_addr + 10'd1;
          idx0      <= idx0 + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ready <= 1'b0;
    else if (line_ok)   ready <= 1'b0;
    else if (last_wr)   ready <= 1'b1;
    else if (pix_start) ready <= 1'b0;
  end

  assign wr_ptr = BW'(idx2) + (rd_sel ? BW'(0) : BW'(COLS));

  always_ff @(posedge clk) begin
    if (vld_pipe[2]) lbuf[wr_ptr] <= {attr, font_data};
  end

  // pixel side: a pix_start in this cycle already selects the new bank and x = 0
  logic          swap, sel_eff, vld_eff;
  logic [XW-1:0] x_eff;
  logic [BW-1:0] rd_ptr;
  logic [15:0]   ent;

  assign swap    = pix_start && ready;
  assign sel_eff = rd_sel ^ swap;
  assign vld_eff = bank_vld[sel_eff] | swap;
  assign x_eff   = pix_start ? '0 : x;
  assign rd_ptr  = BW'(x_eff[XW-1:3]) + (sel_eff ? BW'(COLS) : BW'(0));
  assign ent     = lbuf[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel    <= 1'b0;
      bank_vld  <= '0;
      x         <= XW'(PIXELS);
      pix_valid <= 1'b0;
      pix_color <= '0;
    end else begin
      if (swap) begin
        rd_sel            <= ~rd_sel;
        bank_vld[~rd_sel] <= 1'b1;
      end
      if (pix_en && (x_eff < XW'(PIXELS))) begin
        pix_valid <= 1'b1;
        pix_color <= !vld_eff ? 4'h0 : (ent[~x_eff[2:0]] ? ent[15:12] : ent[11:8]);
        x         <= x_eff + XW'(1);
      end else begin
        pix_valid <= 1'b0;
        pix_color <= 4'h0;
        x         <= x_eff;
      end
    end
  end

endmodule

// File: tb/tb_aqp_ovl_text_render.sv
// Directed bench for aqp_ovl_text_render with behavioural text/font RAMs.
module tb_aqp_ovl_text_render;
  localparam int COLS = 40, ROWS = 25, PIXELS = 320;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        line_start = 1'b0, pix_start = 1'b0, pix_en = 1'b0;
  logic [7:0]  line_idx = '0;
  logic [9:0]  text_addr;
  logic [15:0] text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  pix_color;
  logic        pix_valid, busy;

  int checks = 0, failures = 0;
  int nvalid;

  logic [15:0] tram [1024];
  logic [7:0]  fram [2048];

  aqp_ovl_text_render #(.COLS(COLS), .ROWS(ROWS), .PIXELS(PIXELS)) dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_idx(line_idx),
    .text_addr(text_addr), .text_data(text_data), .font_addr(font_addr),
    .font_data(font_data), .pix_start(pix_start), .pix_en(pix_en),
    .pix_color(pix_color), .pix_valid(pix_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    text_data <= tram[text_addr];
    font_data <= fram[font_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference colour of pixel x on visible line 'line', straight from the RAM images
  function automatic logic [3:0] model(input int line, input int px);
    logic [15:0] d;
    logic [7:0]  p;
    logic [10:0] fa;
    d  = tram[(line / 8) * COLS + px / 8];
    fa = {d[7:0], 3'(line % 8)};
    p  = fram[fa];
    return p[7 - (px % 8)] ? d[15:12] : d[11:8];
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 1024; a++) tram[a] = {8'h23, 8'(a)};
    for (int f = 0; f < 2048; f++) fram[f] = 8'(f >> 3) ^ 8'(f & 7);
    tram[41]      = 16'h1F41;
    fram[11'h20B] = 8'h81;

    // reset values
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_color", pix_color, 0);
    chk("rst_taddr", text_addr, 0);
    chk("rst_faddr", font_addr, 0);
    reset_n = 1'b1;
    tick();

    // out-of-range line is ignored
    line_idx = 8'd200; line_start = 1'b1;
    tick(); line_start = 1'b0;
    chk("oor_busy", busy, 0);
    chk("oor_taddr", text_addr, 0);
    tick();
    chk("oor_busy2", busy, 0);

    // pix_start mid-fetch: no swap, bank still invalid
    line_idx = 8'd0; line_start = 1'b1;
    tick(); line_start = 1'b0;
    repeat (4) tick();
    pix_start = 1'b1; pix_en = 1'b1;
    tick(); pix_start = 1'b0; pix_en = 1'b0;
    chk("inv_valid", pix_valid, 1);
    chk("inv_color", pix_color, 0);
    chk("inv_busy", busy, 1);
    wait_idle("fetch0_done");
    pix_start = 1'b1; pix_en = 1'b1;
    for (int px = 0; px < 16; px++) begin
      tick(); pix_start = 1'b0;
      chk("line0_px", pix_color, model(0, px));
    end
    pix_en = 1'b0;

    // line 11: address timing, completion timing, hand-computed pixels
    line_idx = 8'd11; line_start = 1'b1;
    tick(); line_start = 1'b0;
    chk("l11_taddr_c1", text_addr, 40);
    chk("l11_busy_c1", busy, 1);
    tick();
    chk("l11_taddr_c2", text_addr, 41);
    repeat (40) tick();
    chk("l11_busy_c42", busy, 1);
    tick();
    chk("l11_busy_c43", busy, 0);
    pix_start = 1'b1; pix_en = 1'b1;
    for (int px = 0; px < 16; px++) begin
      tick(); pix_start = 1'b0;
      if (px == 8 || px == 15)      chk("l11_px_fg", pix_color, 4'h1);
      else if (px >= 9 && px <= 14) chk("l11_px_bg", pix_color, 4'hF);
      else                          chk("l11_px", pix_color, model(11, px));
    end
    pix_en = 1'b0;
    tick();
    chk("l11_idle_valid", pix_valid, 0);
    chk("l11_idle_color", pix_color, 0);

    // abort at cycle 10 and restart on line 8
    line_idx = 8'd0; line_start = 1'b1;
    tick(); line_start = 1'b0;
    repeat (9) tick();
    line_idx = 8'd8; line_start = 1'b1;
    tick(); line_start = 1'b0;
    chk("abort_busy", busy, 1);
    repeat (41) tick();
    chk("abort_busy_c52", busy, 1);
    tick();
    chk("abort_done_c53", busy, 0);

    // swap to line 8 while line 16 fetch starts in the same cycle; 400 pix_en
    line_idx = 8'd16; line_start = 1'b1; pix_start = 1'b1; pix_en = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 400; i++) begin
      tick(); line_start = 1'b0; pix_start = 1'b0;
      if (i == 0) chk("both_busy", busy, 1);
      if (pix_valid) begin
        chk("line8_px", pix_color, model(8, nvalid));
        nvalid++;
      end
    end
    chk("line8_count", nvalid, PIXELS);
    chk("sat_valid", pix_valid, 0);
    chk("sat_color", pix_color, 0);
    pix_en = 1'b0;
    wait_idle("fetch16_done");
    pix_start = 1'b1; pix_en = 1'b1;
    for (int px = 0; px < 16; px++) begin
      tick(); pix_start = 1'b0;
      chk("line16_px", pix_color, model(16, px));
    end
    pix_en = 1'b0;

    // reset during fetch column 20
    line_idx = 8'd24; line_start = 1'b1;
    tick(); line_start = 1'b0;
    repeat (20) tick();
    chk("mid_taddr", text_addr, 140);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_taddr", text_addr, 0);
    chk("arst_faddr", font_addr, 0);
    chk("arst_valid", pix_valid, 0);
    chk("arst_color", pix_color, 0);
    #1 reset_n = 1'b1;
    tick();
    pix_start = 1'b1; pix_en = 1'b1;
    tick(); pix_start = 1'b0; pix_en = 1'b0;
    chk("post_rst_valid", pix_valid, 1);
    chk("post_rst_color", pix_color, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
